axis_fifo_pkt: RTL
==================

Name: axis_fifo_pkt

Overview:
Single-clock, parametrised AXI-Stream FIFO. It is the successor to the dual-clock axiss_fifo and carries {tlast, tdata} per beat. It adds an optional store-and-forward packet mode, an occupancy level output and an almost-full flag. It sits between stream producers and consumers inside one clock domain, for packet buffering and rate decoupling.

Parameters:
DATA_WIDTH, 8, width of tdata in bits.
ADDR_DEPTH, 4, log2 of storage depth; depth = 2**ADDR_DEPTH beats.
PACKET_MODE, 0, 0 = stream (cut-through), 1 = store-and-forward (output held until a full packet is stored).
ALMOST_FULL_THRESH, 12, level at or above which almost_full asserts; legal range 1..2**ADDR_DEPTH.

Ports:
aclk  in  1  clock; all logic on rising edge.
areset  in  1  synchronous reset, active-high.
m_tdata  in  DATA_WIDTH  write-side data.
m_tvalid  in  1  write-side valid.
m_tready  out  1  write-side ready.
m_tlast  in  1  write-side end-of-packet.
s_tdata  out  DATA_WIDTH  read-side data.
s_tvalid  out  1  read-side valid.
s_tready  in  1  read-side ready.
s_tlast  out  1  read-side end-of-packet.
level  out  ADDR_DEPTH+1  stored beat count, 0..2**ADDR_DEPTH.
almost_full  out  1  level >= ALMOST_FULL_THRESH.
pkt_count  out  ADDR_DEPTH+1  complete packets stored (tlast beats held).

Behaviour:
- Reset, sampled on aclk while areset=1:
  - Write pointer, read pointer, level, pkt_count and the flush bit all clear to 0.
  - m_tready=0 and s_tvalid=0 during reset. m_tready=1 on the first cycle after areset falls.
  - Memory contents are not reset; s_tdata and s_tlast are don't-care while s_tvalid=0.
  - Reset mid-packet discards all stored data. No partial packet survives reset.
- Handshakes:
  - Write when m_tvalid & m_tready.
  - Read when s_tvalid & s_tready.
  - m_tready = (level != depth), combinational from registered level.
  - s_tvalid and s_tdata do not depend combinationally on s_tready. s_tvalid, s_tdata and s_tlast are stable while s_tvalid=1 and s_tready=0.
- Latency (stream mode): a beat accepted at edge N shows on s_tdata/s_tvalid in the cycle after edge N, i.e. 1 cycle. Output is first-word-fall-through.
- Pointers are ADDR_DEPTH bits wide and wrap modulo depth without a gap.
- Level:
  - Write only: +1. Read only: -1. Both in the same cycle: unchanged.
  - Full: no write. Empty: no read. A simultaneous read and write while full or empty is therefore impossible by construction.
- pkt_count:
  - +1 on a write with m_tlast=1. -1 on a read with s_tlast=1. Both in the same cycle: unchanged.
- Packet mode (PACKET_MODE=1):
  - s_tvalid = (level != 0) & (pkt_count != 0 | flush).
  - flush bit sets when level == depth and pkt_count == 0, i.e. an oversize packet would deadlock.
  - flush clears on the read of a beat with s_tlast=1. While set, the FIFO behaves cut-through.
  - A tlast write in the same cycle flush sets has no effect on flush.
- Stream mode (PACKET_MODE=0): s_tvalid = (level != 0). flush is unused and held at 0.
- almost_full is combinational from registered level.
- The count outputs never exceed depth; no internal arithmetic overflows at ADDR_DEPTH+1 bits.

Test Plan:
1. Stream mode, defaults, s_tready=0: write 16 beats 0x00..0x0F -> m_tready falls after the 16th accept; level=16; almost_full=1 from level 12. Then s_tready=1 -> 0x00..0x0F read in order, one per cycle; level returns to 0; s_tvalid=0.
2. Stream latency: single write of 0xA5 at edge N with s_tready=1 -> s_tvalid=1 and s_tdata=0xA5 in the cycle after edge N; level returns to 0 after the read.
3. Packet mode: write 3 beats 0x11, 0x22, 0x33 with tlast on 0x33, s_tready=1 throughout -> s_tvalid=0 until the cycle after 0x33 is accepted; then 0x11, 0x22, 0x33 are read with s_tlast only on 0x33; pkt_count goes 0→1→0.
4. Continuous write/read: m_tvalid=1 and s_tready=1 for 40 cycles at level=5 -> level stays 5; pointers wrap twice; data order is preserved with no gaps.
5. Packet mode, oversize packet: write 16 beats with no tlast -> flush sets at level 16; s_tvalid=1 and data drains. Write a 17th beat with tlast -> read with s_tlast=1; flush clears; pkt_count=0.
6. Reset mid-operation: level=7, pkt_count=2, assert areset for 1 cycle -> next cycle level=0, pkt_count=0, s_tvalid=0, m_tready=1. A new write of 0x5A then reads back 0x5A.

Source files
------------

// File: rtl/axis_fifo_pkt.sv
// -----------------------------------------------------------------------------
// axis_fifo_pkt
//
// Single-clock AXI-Stream FIFO carrying {tlast, tdata} per beat. The read side
// is first-word-fall-through: a beat accepted on one edge is presented on the
// next cycle. In packet mode (PACKET_MODE=1) the read side stays invalid until
// at least one complete packet (a beat with tlast) is stored. If the FIFO fills
// without holding a tlast, a flush bit turns it cut-through until that
// oversize packet's tlast beat has been read, so it cannot deadlock.
//
// Parameters
//   DATA_WIDTH          width of tdata
//   ADDR_DEPTH          log2 of storage depth (depth = 2**ADDR_DEPTH beats)
//   PACKET_MODE         0 = cut-through stream, 1 = store-and-forward
//   ALMOST_FULL_THRESH  level at or above which almost_full asserts
//
// Ports
//   aclk, areset        clock; synchronous active-high reset
//   m_tdata/m_tvalid/m_tlast -> m_tready     write side
//   s_tdata/s_tvalid/s_tlast <- s_tready     read side
//   level               stored beat count, 0..depth
//   almost_full         level >= ALMOST_FULL_THRESH
//   pkt_count           number of stored tlast beats
// -----------------------------------------------------------------------------
module axis_fifo_pkt #(
  parameter int DATA_WIDTH         = 8,
  parameter int ADDR_DEPTH         = 4,
  parameter int PACKET_MODE        = 0,
  parameter int ALMOST_FULL_THRESH = 12
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [DATA_WIDTH-1:0] m_tdata,
  input  logic                  m_tvalid,
  output logic                  m_tready,
  input  logic                  m_tlast,
  output logic [DATA_WIDTH-1:0] s_tdata,
  output logic                  s_tvalid,
  input  logic                  s_tready,
  output logic                  s_tlast,
  output logic [ADDR_DEPTH:0]   level,
  output logic                  almost_full,
  output logic [ADDR_DEPTH:0]   pkt_count
);

  localparam int                  DEPTH   = 1 << ADDR_DEPTH;
  localparam logic [ADDR_DEPTH:0] DEPTH_C = (ADDR_DEPTH+1)'(DEPTH);
  localparam logic [ADDR_DEPTH:0] AF_C    = (ADDR_DEPTH+1)'(ALMOST_FULL_THRESH);
  localparam logic [ADDR_DEPTH:0] CNT_ONE = (ADDR_DEPTH+1)'(1);
  localparam logic [ADDR_DEPTH-1:0] PTR_ONE = ADDR_DEPTH'(1);

  // Storage: one extra bit per entry holds tlast.
  logic [DATA_WIDTH:0]   mem_q [DEPTH];

  logic [ADDR_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_DEPTH:0]   level_q, level_d;
  logic [ADDR_DEPTH:0]   pkt_q, pkt_d;
  logic                  flush_q, flush_d;

  logic                  wr_en, rd_en;
  logic                  wr_last, rd_last;
  logic                  avail;
  logic [DATA_WIDTH:0]   rd_word;

  // ---------------------------------------------------------------------------
  // Handshake and output decode
  // ---------------------------------------------------------------------------
  // Both ready and valid are forced low while reset is asserted so that no
  // beat can be transferred in the reset cycle, whatever the stale level is.
  assign m_tready = ~areset & (level_q != DEPTH_C);

  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first so no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    avail = (level_q != '0);
    if (PACKET_MODE != 0) begin
      avail = (level_q != '0) & ((pkt_q != '0) | flush_q);
    end
  end

  assign s_tvalid = ~areset & avail;

  // The read word comes straight from the array at the read pointer; the entry
  // there cannot be overwritten while it is unread, so data holds steady
  // during back-pressure.
  assign rd_word = mem_q[rd_ptr_q];
  assign s_tdata = rd_word[DATA_WIDTH-1:0];
  assign s_tlast = rd_word[DATA_WIDTH];

  assign wr_en   = m_tvalid & m_tready;
  assign rd_en   = s_tvalid & s_tready;
  assign wr_last = wr_en & m_tlast;
  assign rd_last = rd_en & s_tlast;

  assign level       = level_q;
  assign pkt_count   = pkt_q;
  assign almost_full = (level_q >= AF_C);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    pkt_d    = pkt_q;
    flush_d  = 1'b0;

    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;

    unique case ({wr_en, rd_en})
      2'b10:   level_d = level_q + CNT_ONE;
      2'b01:   level_d = level_q - CNT_ONE;
      default: level_d = level_q;
    endcase

    unique case ({wr_last, rd_last})
      2'b10:   pkt_d = pkt_q + CNT_ONE;
      2'b01:   pkt_d = pkt_q - CNT_ONE;
      default: pkt_d = pkt_q;
    endcase

    if (PACKET_MODE != 0) begin
      // Full with no complete packet stored can only be drained by going
      // cut-through; the set test uses registered state, so a tlast written in
      // the same cycle does not stop flush from setting.
      flush_d = flush_q;
      if (rd_last) flush_d = 1'b0;
      if ((level_q == DEPTH_C) && (pkt_q == '0)) flush_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      pkt_q    <= '0;
      flush_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      pkt_q    <= pkt_d;
      flush_q  <= flush_d;
    end
  end

  // NOTE: the storage array has no reset; stale contents are never visible
  // because s_tvalid is low until the entry has been written, and leaving the
  // reset off lets the array map onto plain RAM.
  always_ff @(posedge aclk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {m_tlast, m_tdata};
  end

endmodule
